// File: rtl/fat_sector_streamer.sv
// Rewrites one FAT sector: requests an SD block write, sweeps the FAT-list generator and
// streams its bytes through a skid FIFO. Define FAT_MIRROR_EN to also rewrite the FAT2 copy.
module fat_sector_streamer #(
    parameter int theSizeofBlock = 512,
    parameter int indexWidth     = 32,
    parameter int ReadLatency    = 2,
    parameter int SkidDepth      = 4
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  NeedUpdateFat,
    input  logic [31:0]           FileSectorLength,
    input  logic [31:0]           FatStartSector,
    input  logic [indexWidth-1:0] StartAddress,
    input  logic [31:0]           FatBaseSector,
    input  logic [31:0]           SectorsPerFat,
    output logic [indexWidth-1:0] FatAddress,
    input  logic [7:0]            FatByte,
    output logic                  WriteRequest,
    output logic [31:0]           WriteSector,
    input  logic                  WriteGrant,
    output logic                  ByteValid,
    output logic [7:0]            ByteData,
    input  logic                  ByteReady,
    input  logic                  WriteDone,
    output logic                  Busy,
    output logic                  UpdateDone
);

    localparam int PW = (SkidDepth > 1) ? $clog2(SkidDepth) : 1;
    localparam int CW = $clog2(SkidDepth + 1);
    localparam int OW = $clog2(SkidDepth + ReadLatency + 2);
    localparam logic [9:0] BLOCK_LEN  = 10'(theSizeofBlock);
    localparam logic [9:0] BLOCK_LAST = 10'(theSizeofBlock - 1);

    typedef enum logic [2:0] {IDLE, REQUEST, STREAM, WAIT_DONE, DONE} state_t;

    state_t                 state, state_next;
    logic [31:0]            last_serviced;
    logic [indexWidth-1:0]  start_lat;
    logic [9:0]             issue_cnt, sent_cnt;
    logic [ReadLatency-1:0] return_pipe;
    logic [7:0]             fifo_mem [SkidDepth];
    logic [PW-1:0]          wr_ptr, rd_ptr;
    logic [CW-1:0]          fifo_count;
    logic [OW-1:0]          occupancy;
    logic                   trigger, issue, push, pop;

`ifdef FAT_MIRROR_EN
    logic [31:0] sector_lat;
    logic        mirror_copy;
`else
    logic unused_spf;
    assign unused_spf = ^SectorsPerFat;
`endif

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(SkidDepth - 1)) ? '0 : p + PW'(1);
    endfunction

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next   = state;
        trigger      = NeedUpdateFat && (FileSectorLength != '0) &&
                       (FileSectorLength != last_serviced);
        occupancy    = OW'(fifo_count) + OW'($countones(return_pipe));
        // Byte 0 is issued in the grant cycle so the first byte appears ReadLatency+1 cycles later.
        issue        = ((state == STREAM) || ((state == REQUEST) && WriteGrant)) &&
                       (issue_cnt != BLOCK_LEN) && (occupancy < OW'(SkidDepth));
        push         = return_pipe[ReadLatency-1];
        ByteValid    = (state == STREAM) && (fifo_count != '0);
        pop          = ByteValid && ByteReady;
        WriteRequest = (state == REQUEST);
        UpdateDone   = (state == DONE);
        ByteData     = fifo_mem[rd_ptr];
        FatAddress   = start_lat + indexWidth'(issue_cnt);
        case (state)
            IDLE:      if (trigger) state_next = REQUEST;
            REQUEST:   if (WriteGrant) state_next = STREAM;
            STREAM:    if (pop && (sent_cnt == BLOCK_LAST)) state_next = WAIT_DONE;
            WAIT_DONE: if (WriteDone) begin
`ifdef FAT_MIRROR_EN
                state_next = mirror_copy ? DONE : REQUEST;
`else
                state_next = DONE;
`endif
            end
            DONE:      state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            Busy          <= 1'b0;
            WriteSector   <= '0;
            last_serviced <= '0;
            start_lat     <= '0;
            issue_cnt     <= '0;
            sent_cnt      <= '0;
            return_pipe   <= '0;
            fifo_mem      <= '{default: '0};
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            fifo_count    <= '0;
`ifdef FAT_MIRROR_EN
            sector_lat    <= '0;
            mirror_copy   <= 1'b0;
`endif
        end else begin
            return_pipe <= (return_pipe << 1) | ReadLatency'(issue);
            if (issue) issue_cnt <= issue_cnt + 10'd1;
            if (pop)   sent_cnt  <= sent_cnt + 10'd1;
            if (push) begin
                fifo_mem[wr_ptr] <= FatByte;
                wr_ptr           <= ptr_inc(wr_ptr);
            end
            if (pop) rd_ptr <= ptr_inc(rd_ptr);
            if (push && !pop)      fifo_count <= fifo_count + CW'(1);
            else if (pop && !push) fifo_count <= fifo_count - CW'(1);

            if ((state == IDLE) && trigger) begin
                start_lat     <= StartAddress;
                last_serviced <= FileSectorLength;
                WriteSector   <= FatBaseSector + FatStartSector;
                Busy          <= 1'b1;
                issue_cnt     <= '0;
                sent_cnt      <= '0;
`ifdef FAT_MIRROR_EN
                sector_lat    <= FatStartSector;
                mirror_copy   <= 1'b0;
`endif
            end
`ifdef FAT_MIRROR_EN
            if ((state == WAIT_DONE) && WriteDone && !mirror_copy) begin
                mirror_copy <= 1'b1;
                WriteSector <= FatBaseSector + SectorsPerFat + sector_lat;
                issue_cnt   <= '0;
                sent_cnt    <= '0;
            end
`endif
            if (state == DONE) Busy <= 1'b0;
        end
    end

    // Credit accounting makes this unreachable; it guards future parameter changes.
    assert property (@(posedge Clock) disable iff (Reset)
        !(push && (fifo_count == CW'(SkidDepth))));

endmodule
